ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_pkg.sv | 42 ++++
 rtl/ahb_sram_mem.sv | 27 ++
 rtl/ahb_sram_slave.sv | 152 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and byte-lane helper for the SRAM slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      SIZE_BYTE = 3'd0,
      SIZE_HALF = 3'd1,
      SIZE_WORD = 3'd2
   } hsize_t;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } hresp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // Little-endian byte enables for an aligned transfer of the given size.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SIZE_BYTE: be = 4'b0001 << addr_lo;
         SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: byte-enabled synchronous write, combinational read, no reset.
module ahb_sram_mem #(
   parameter int WORDS = 256,
   parameter int AW    = 8
) (
   input  logic          clk_sys,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // Commit only the enabled byte lanes; others keep their contents.
   always_ff @(posedge clk_sys) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with configurable data-phase wait states and two-cycle ERROR response.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready; if pend_q is set this is the final data phase of a transfer
// ST_WAIT | stalling a valid transfer, wait_cnt counts down to terminal 0
// ST_ERR1 | first error cycle: HREADYOUT=0, HRESP=ERROR
// ST_ERR2 | second error cycle: HREADYOUT=1, HRESP=ERROR
module ahb_sram_slave import ahb_pkg::*; #(
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int WORDS = MEM_BYTES / 4;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [1:0] CNT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic            write_q, write_d;
   logic [2:0]      size_q, size_d;

   logic            accept;
   logic            misaligned;
   logic            req_err;
   logic            ready_o;
   hresp_t          resp_o;
   logic            final_dp;
   logic            mem_we;
   logic [31:0]     mem_rdata;
   logic            unused_hburst;

   // Burst type is irrelevant: every beat is decoded on its own.
   assign unused_hburst = ^HBURST;

   assign accept = HSEL & HREADY & HTRANS[1];

   // Alignment check for the incoming address phase.
   always_comb begin
      misaligned = 1'b0;
      case (HSIZE)
         SIZE_HALF: misaligned = HADDR[0];
         SIZE_WORD: misaligned = |HADDR[1:0];
         default:   misaligned = 1'b0;
      endcase
   end

   assign req_err = (HSIZE > SIZE_WORD) | misaligned | (HADDR >= 32'(MEM_BYTES));

   // State and captured address-phase controls.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   // Next state and bus handshake; a new address phase is taken in any ready cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      ready_o = 1'b1;
      resp_o  = RESP_OKAY;

      case (state_q)
         ST_IDLE: pend_d = 1'b0;
         ST_WAIT: begin
            ready_o = 1'b0;
            if (cnt_q == 2'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 2'd1;
         end
         ST_ERR1: begin
            ready_o = 1'b0;
            resp_o  = RESP_ERROR;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            resp_o  = RESP_ERROR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (ready_o && accept) begin
         addr_d  = HADDR[AW+1:0];
         write_d = HWRITE;
         size_d  = HSIZE;
         if (req_err) begin
            state_d = ST_ERR1;
            pend_d  = 1'b0;
         end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   assign final_dp  = (state_q == ST_IDLE) && pend_q;
   assign mem_we    = final_dp && write_q;
   assign HREADYOUT = ready_o;
   assign HRESP     = resp_o;
   assign HRDATA    = (final_dp && !write_q) ? mem_rdata : 32'd0;

   ahb_sram_mem #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_mem (
      .clk_sys (HCLK),
      .we      (mem_we),
      .be      (byte_lanes(size_q, addr_q[1:0])),
      .addr    (addr_q[AW+1:2]),
      .wdata   (HWDATA),
      .rdata   (mem_rdata)
   );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one slave with no wait states, one with two wait states.
module tb_ahb_sram_slave;

   logic        clk = 1'b0;
   logic        HRESET;
   logic [1:0]  hsel;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [1:0]  hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata0, hrdata1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HWDATA(HWDATA),
      .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata0)
   );

   ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(2)) dut1 (
      .HCLK(clk), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'd0), .HWDATA(HWDATA),
      .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single transfer followed by idle; reports stalls, responses and read data.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int stalls,
                       output logic resp_stall, output logic resp_fin);
      logic done;
      hsel   = (d == 0) ? 2'b01 : 2'b10;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = size;
      HTRANS = 2'b10;
      step();
      hsel       = 2'b00;
      HTRANS     = 2'b00;
      HWDATA     = wdata;
      stalls     = 0;
      resp_stall = 1'b0;
      resp_fin   = 1'b0;
      rdata      = 32'd0;
      done       = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         if (hreadyout[d]) begin
            rdata    = (d == 0) ? hrdata0 : hrdata1;
            resp_fin = hresp[d];
            done     = 1'b1;
         end else begin
            stalls++;
            resp_stall = resp_stall | hresp[d];
         end
         step();
      end
      if (!done) chk("timeout", 32'(done), 32'd1);
      HWDATA = 32'd0;
   endtask

   initial begin
      logic [31:0] rd;
      int          st;
      logic        rs, rf;

      HRESET = 1'b1;
      hsel   = 2'b00;
      HADDR  = 32'd0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
      HWDATA = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      HRESET = 1'b0;

      chk("rst_ready", 32'(hreadyout), 32'h3);
      chk("rst_resp", 32'(hresp), 32'h0);
      chk("rst_rdata0", hrdata0, 32'h0);
      chk("rst_rdata1", hrdata1, 32'h0);

      // Zero-wait word write then read.
      xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, st, rs, rf);
      chk("ws0_wr_stalls", 32'(st), 32'd0);
      chk("ws0_wr_resp", 32'(rf), 32'd0);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, st, rs, rf);
      chk("ws0_rd_data", rd, 32'hDEADBEEF);
      chk("ws0_rd_stalls", 32'(st), 32'd0);
      chk("ws0_rd_resp", 32'(rf), 32'd0);
      chk("idle_rdata", hrdata0, 32'h0);

      // Byte and halfword lane writes.
      xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, st, rs, rf);
      xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, rd, st, rs, rf);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, st, rs, rf);
      chk("byte_wr", rd, 32'hAA223344);
      xfer(0, 1'b1, 32'h10, 3'd1, 32'h00005566, rd, st, rs, rf);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, st, rs, rf);
      chk("half_wr", rd, 32'hAA225566);

      // Error: misaligned word beyond memory.
      xfer(0, 1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, st, rs, rf);
      xfer(0, 1'b1, 32'h402, 3'd2, 32'hFFFFFFFF, rd, st, rs, rf);
      chk("err_stalls", 32'(st), 32'd1);
      chk("err1_resp", 32'(rs), 32'd1);
      chk("err2_resp", 32'(rf), 32'd1);
      xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, st, rs, rf);
      chk("err_mem_keep", rd, 32'h0BADF00D);
      chk("after_err_resp", 32'(rf), 32'd0);

      // Error: misaligned halfword in range leaves memory untouched.
      xfer(0, 1'b1, 32'h11, 3'd1, 32'hFFFFFFFF, rd, st, rs, rf);
      chk("mis_half_resp", 32'(rf), 32'd1);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, st, rs, rf);
      chk("mis_half_keep", rd, 32'hAA225566);

      // Back-to-back write then read of the same word.
      hsel   = 2'b01;
      HADDR  = 32'h8;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      HTRANS = 2'b10;
      step();
      HWDATA = 32'h12345678;
      HWRITE = 1'b0;
      chk("b2b_wr_ready", 32'(hreadyout[0]), 32'd1);
      chk("b2b_wr_rdata", hrdata0, 32'h0);
      step();
      hsel   = 2'b00;
      HTRANS = 2'b00;
      HWDATA = 32'd0;
      chk("b2b_rd_ready", 32'(hreadyout[0]), 32'd1);
      chk("b2b_rd_data", hrdata0, 32'h12345678);
      step();

      // Two wait states.
      xfer(1, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd, st, rs, rf);
      chk("ws2_wr_stalls", 32'(st), 32'd2);
      xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, st, rs, rf);
      chk("ws2_rd_stalls", 32'(st), 32'd2);
      chk("ws2_rd_stall_resp", 32'(rs), 32'd0);
      chk("ws2_rd_resp", 32'(rf), 32'd0);
      chk("ws2_rd_data", rd, 32'hCAFEF00D);

      // Errors ignore wait states.
      xfer(1, 1'b0, 32'h0, 3'd3, 32'h0, rd, st, rs, rf);
      chk("ws2_err_stalls", 32'(st), 32'd1);
      chk("ws2_err_resp", 32'(rf), 32'd1);

      // Reset during WAIT aborts the write.
      xfer(1, 1'b1, 32'h20, 3'd2, 32'h77777777, rd, st, rs, rf);
      hsel   = 2'b10;
      HADDR  = 32'h20;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      HTRANS = 2'b10;
      step();
      hsel   = 2'b00;
      HTRANS = 2'b00;
      HWDATA = 32'h00000055;
      chk("wait_ready_low", 32'(hreadyout[1]), 32'd0);
      HRESET = 1'b1;
      step();
      HRESET = 1'b0;
      HWDATA = 32'd0;
      chk("rst_wait_ready", 32'(hreadyout[1]), 32'd1);
      chk("rst_wait_resp", 32'(hresp[1]), 32'd0);
      chk("rst_wait_rdata", hrdata1, 32'h0);
      step();
      chk("post_rst_ready", 32'(hreadyout[1]), 32'd1);
      xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, st, rs, rf);
      chk("rst_abort_keep", rd, 32'h77777777);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
